rs_issue_scheduler: RTL and testbench

//  Reservation-station scheduler between instruction decompose and the ALU/LSU issue ports.

---
 rtl/rs_issue_scheduler.sv | 153 +++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler
//  Description : Collapsing-queue reservation station. Buffers decomposed
//                instructions in age order (slot 0 oldest), snoops the
//                writeback bus to wake pending sources, and issues the oldest
//                entry whose two sources are valid.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_issue_scheduler #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 83,
  parameter int TAG_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INST_W-1:0]            in_inst,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  input  logic [31:0]                  wb_value,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [INST_W-1:0]            issue_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  // Field positions inside a decomposed instruction
  localparam int c_s1_v   = 5;
  localparam int c_rs1_lo = 6;
  localparam int c_s2_v   = 38;
  localparam int c_rs2_lo = 39;

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][INST_W-1:0] r_inst;
  logic [CW-1:0]                r_count;

  logic [DEPTH-1:0]             w_rdy;
  logic [DEPTH-1:0]             w_sel_oh;
  logic [DEPTH-1:0]             w_above;
  logic [DEPTH-1:0]             w_up_v;
  logic [DEPTH-1:0][INST_W-1:0] w_up_inst;
  logic [DEPTH-1:0]             w_shift;
  logic [DEPTH-1:0]             w_base_v;
  logic [DEPTH-1:0][INST_W-1:0] w_base_inst;
  logic [DEPTH-1:0]             w_ins_here;
  logic [DEPTH-1:0]             w_nxt_v;
  logic [DEPTH-1:0][INST_W-1:0] w_nxt_inst;
  logic                         w_wake_en;
  logic                         w_ins_fire;
  logic                         w_iss_fire;
  logic [CW-1:0]                w_ins_pos;
  logic [CW-1:0]                w_nxt_count;
  logic [INST_W-1:0]            w_in_woken;

  // Apply a writeback broadcast to both sources of one instruction
  function automatic logic [INST_W-1:0] wake(
    input logic [INST_W-1:0] inst,
    input logic              en,
    input logic [TAG_W-1:0]  tag,
    input logic [31:0]       val
  );
    logic [INST_W-1:0] res;
    res = inst;
    if (en && !inst[c_s1_v] && (inst[c_rs1_lo +: TAG_W] == tag)) begin
      res[c_rs1_lo +: 32] = val;
      res[c_s1_v]         = 1'b1;
    end
    if (en && !inst[c_s2_v] && (inst[c_rs2_lo +: TAG_W] == tag)) begin
      res[c_rs2_lo +: 32] = val;
      res[c_s2_v]         = 1'b1;
    end
    return res;
  endfunction

  // Tag 0 never matches: it marks "no producer"
  assign w_wake_en  = wb_valid && (wb_tag != '0);
  assign in_ready   = (r_count < CW'(DEPTH));
  assign count      = r_count;
  assign w_ins_fire = in_valid && in_ready;
  assign w_iss_fire = issue_valid && issue_ready;
  assign w_ins_pos  = r_count - {{(CW-1){1'b0}}, w_iss_fire};
  assign w_in_woken = wake(in_inst, w_wake_en, wb_tag, wb_value);

  // Oldest-ready priority pick; w_above marks the selected slot and all above it
  always_comb begin
    logic found;
    found    = 1'b0;
    w_sel_oh = '0;
    w_above  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i]    = r_v[i] && r_inst[i][c_s1_v] && r_inst[i][c_s2_v];
      w_sel_oh[i] = w_rdy[i] && !found;
      found       = found || w_rdy[i];
      w_above[i]  = found;
    end
  end

  // Selected entry to the issue port; zero when nothing is ready
  always_comb begin
    issue_valid = |w_sel_oh;
    issue_inst  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) issue_inst = issue_inst | r_inst[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    // Neighbour above feeds this slot when the queue collapses
    if (i < DEPTH-1) begin : g_mid
      assign w_up_v[i]    = r_v[i+1];
      assign w_up_inst[i] = r_inst[i+1];
    end else begin : g_top
      assign w_up_v[i]    = 1'b0;
      assign w_up_inst[i] = '0;
    end
    assign w_shift[i]     = w_iss_fire && w_above[i];
    assign w_base_v[i]    = w_shift[i] ? w_up_v[i]    : r_v[i];
    assign w_base_inst[i] = w_shift[i] ? w_up_inst[i] : r_inst[i];
    // Insert lands in the first free slot after the collapse
    assign w_ins_here[i]  = w_ins_fire && (w_ins_pos == CW'(i));
    assign w_nxt_v[i]     = w_ins_here[i] || w_base_v[i];
    assign w_nxt_inst[i]  = w_ins_here[i] ? w_in_woken :
                            (w_base_v[i] ? wake(w_base_inst[i], w_wake_en, wb_tag, wb_value)
                                         : w_base_inst[i]);
  end

  assign w_nxt_count = r_count + {{(CW-1){1'b0}}, w_ins_fire}
                               - {{(CW-1){1'b0}}, w_iss_fire};

  // Entry storage and occupancy; flush overrides all concurrent activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_inst  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_v     <= '0;
      r_inst  <= '0;
      r_count <= '0;
    end else begin
      r_v     <= w_nxt_v;
      r_inst  <= w_nxt_inst;
      r_count <= w_nxt_count;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_issue_scheduler
//  Description : Directed self-checking bench for rs_issue_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_issue_scheduler;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [82:0] in_inst;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [82:0] issue_inst;
  logic [2:0]  count;

  int total;
  int bad;

  rs_issue_scheduler #(.DEPTH(4), .INST_W(83), .TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_value    (wb_value),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_inst  (issue_inst),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [82:0] mk(input logic [11:0] ctrl, input logic [31:0] rs2,
                                     input logic s2v, input logic [31:0] rs1,
                                     input logic s1v, input logic [4:0] rd);
    return {ctrl, rs2, s2v, rs1, s1v, rd};
  endfunction

  // Pool entry k: rs1 pending on tag 10+k unless woken with a value
  function automatic logic [82:0] pend(input int k);
    return mk(12'(k), 32'hA0 + 32'(k), 1'b1, 32'(10 + k), 1'b0, 5'(k));
  endfunction
  function automatic logic [82:0] woke(input int k, input logic [31:0] v);
    return mk(12'(k), 32'hA0 + 32'(k), 1'b1, v, 1'b1, 5'(k));
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] t, input logic [31:0] v);
    wb_valid = 1'b1; wb_tag = t; wb_value = v;
    step();
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0;
  endtask

  logic [82:0] i1, a, b, x, n;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0; issue_ready = 1'b0;
    #12;
    check("rst_count",  128'(count), 128'd0);
    check("rst_ready",  128'(in_ready), 128'd1);
    check("rst_ivalid", 128'(issue_valid), 128'd0);
    check("rst_iinst",  128'(issue_inst), 128'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: ready-on-arrival instruction issues next cycle unchanged
    i1 = mk(12'hABC, 32'h1111_2222, 1'b1, 32'h3333_4444, 1'b1, 5'd3);
    in_valid = 1'b1; in_inst = i1;
    step();
    in_valid = 1'b0;
    check("t1_ivalid", 128'(issue_valid), 128'd1);
    check("t1_inst",   128'(issue_inst), 128'(i1));
    check("t1_count",  128'(count), 128'd1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("t1_drain", 128'(count), 128'd0);

    // 2: younger ready entry bypasses older pending one
    a = mk(12'h001, 32'h9, 1'b1, 32'h5, 1'b0, 5'd1);
    b = mk(12'h002, 32'h22, 1'b1, 32'h11, 1'b1, 5'd2);
    in_valid = 1'b1; in_inst = a; step();
    in_inst = b; step();
    in_valid = 1'b0;
    check("t2_b_first", 128'(issue_inst), 128'(b));
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    check("t2_a_wait", 128'(issue_valid), 128'd0);
    wb(5'd5, 32'hDEADBEEF);
    check("t2_a_woke", 128'(issue_inst), 128'(mk(12'h001, 32'h9, 1'b1, 32'hDEADBEEF, 1'b1, 5'd1)));
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    check("t2_drain", 128'(count), 128'd0);

    // 4: same-cycle broadcast captured on insert
    x = mk(12'h044, 32'h7, 1'b0, 32'h55, 1'b1, 5'd4);
    in_valid = 1'b1; in_inst = x;
    wb(5'd7, 32'h12);
    in_valid = 1'b0;
    check("t4_bypass", 128'(issue_inst), 128'(mk(12'h044, 32'h12, 1'b1, 32'h55, 1'b1, 5'd4)));
    issue_ready = 1'b1; step(); issue_ready = 1'b0;

    // 3: fill with pending entries, overflow ignored
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_inst = pend(k); step();
    end
    check("t3_full_cnt", 128'(count), 128'd4);
    check("t3_full_rdy", 128'(in_ready), 128'd0);
    check("t3_none_rdy", 128'(issue_valid), 128'd0);
    in_inst = mk(12'hFFF, 32'h0, 1'b1, 32'h0, 1'b1, 5'd31); step();
    in_valid = 1'b0;
    check("t3_ovf_cnt", 128'(count), 128'd4);
    check("t3_ovf_none", 128'(issue_valid), 128'd0);
    wb(5'd12, 32'hC0DE_000C);
    check("t3_wake2", 128'(issue_inst), 128'(woke(2, 32'hC0DE_000C)));
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    check("t3_cnt3", 128'(count), 128'd3);
    check("t3_rdy1", 128'(in_ready), 128'd1);

    // 5: {P0,P1,P3}; P1 issues while N inserts -> {P0,P3,N}
    wb(5'd11, 32'hC0DE_000B);
    check("t5_p1", 128'(issue_inst), 128'(woke(1, 32'hC0DE_000B)));
    n = mk(12'h0EE, 32'h77, 1'b1, 32'h66, 1'b1, 5'd9);
    issue_ready = 1'b1; in_valid = 1'b1; in_inst = n;
    step();
    issue_ready = 1'b0; in_valid = 1'b0;
    check("t5_cnt", 128'(count), 128'd3);
    check("t5_new", 128'(issue_inst), 128'(n));
    wb(5'd13, 32'hC0DE_000D);
    check("t5_p3_older", 128'(issue_inst), 128'(woke(3, 32'hC0DE_000D)));
    wb(5'd10, 32'hC0DE_000A);
    check("t5_p0_oldest", 128'(issue_inst), 128'(woke(0, 32'hC0DE_000A)));
    wb(5'd0, 32'hBAD0_0000);
    check("t5_tag0_hold", 128'(issue_inst), 128'(woke(0, 32'hC0DE_000A)));

    // 6: flush beats concurrent insert and wakeup
    flush = 1'b1; in_valid = 1'b1; in_inst = pend(5);
    wb(5'd15, 32'h1234);
    flush = 1'b0; in_valid = 1'b0;
    check("t6_fl_cnt", 128'(count), 128'd0);
    check("t6_fl_iv",  128'(issue_valid), 128'd0);
    check("t6_fl_rdy", 128'(in_ready), 128'd1);

    // asynchronous reset mid-traffic
    in_valid = 1'b1; in_inst = i1; step();
    in_inst = pend(1); step();
    check("t6_pre_cnt", 128'(count), 128'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ar_cnt",  128'(count), 128'd0);
    check("t6_ar_iv",   128'(issue_valid), 128'd0);
    check("t6_ar_inst", 128'(issue_inst), 128'd0);
    check("t6_ar_rdy",  128'(in_ready), 128'd1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t6_post_cnt", 128'(count), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
